sdram_xfer_seq: RTL and testbench

//  Sequencer downstream of the CPU register write block.
//  - Turns CPU-written sdram_wr/sdram_rd run bits and begin/end burst addresses into valid/ready burst commands to the SDRAM controller.
//  - Gates commands on write-FIFO fill and read-FIFO space; issues FIFO clear pulses; reports busy/done/count/error to CPU read-back.

---
 rtl/sdram_xfer_seq.sv | 182 ++++++++++++++++++
 tb/tb_sdram_xfer_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_xfer_seq.sv
// Burst command sequencer between the CPU run/clear registers and the SDRAM controller.
// Walks an inclusive begin..end burst range, gating each command on FIFO level.
module sdram_xfer_seq #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int FIFO_AW   = 9
) (
  input  logic              clk,
  input  logic              pRST,
  input  logic              sdram_wr,
  input  logic              sdram_rd,
  input  logic [ADDR_W-1:0] sdram_wraddr_begin,
  input  logic [ADDR_W-1:0] sdram_wraddr_end,
  input  logic [ADDR_W-1:0] sdram_rdaddr_begin,
  input  logic [ADDR_W-1:0] sdram_rdaddr_end,
  input  logic              sdram_pre_clr,
  input  logic              sdram_post_clr,
  input  logic [FIFO_AW:0]  wfifo_used,
  input  logic [FIFO_AW:0]  rfifo_free,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              ctrl_idle,
  output logic              pre_fifo_clr,
  output logic              post_fifo_clr,
  output logic              busy,
  output logic              xfer_done,
  output logic [15:0]       xfer_count,
  output logic              seq_error
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH} state_t;

  localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW + 1)'(BURST_LEN);

  // Request bit order: {post_clr, pre_clr, rd, wr}
  logic [3:0]        req_cur_q, req_prev_q, req_edge;
  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [15:0]       count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pre_clr_q, pre_clr_d;
  logic              post_clr_q, post_clr_d;
  logic              gate_open;
  logic              wr_e, rd_e, pre_e, post_e;

  assign req_edge = req_cur_q & ~req_prev_q;
  assign wr_e     = req_edge[0];
  assign rd_e     = req_edge[1];
  assign pre_e    = req_edge[2];
  assign post_e   = req_edge[3];

  assign gate_open = write_q ? (wfifo_used >= BURST_LVL) : (rfifo_free >= BURST_LVL);

  always_comb begin
    // NOTE: every signal gets its default first so no path through the case leaves it unassigned (no latch).
    state_d    = state_q;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    end_d      = end_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q;
    pre_clr_d  = 1'b0;
    post_clr_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wr_e || rd_e) begin
          // A clear arriving with a run edge is dropped and flagged.
          if (pre_e || post_e) err_d = 1'b1;
          if (wr_e && rd_e) begin
            err_d = 1'b1;
          end else if (wr_e) begin
            if (sdram_wraddr_end >= sdram_wraddr_begin) begin
              state_d = S_ISSUE;
              addr_d  = sdram_wraddr_begin;
              end_d   = sdram_wraddr_end;
              write_d = 1'b1;
              count_d = '0;
              done_d  = 1'b0;
              valid_d = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (sdram_rdaddr_end >= sdram_rdaddr_begin) begin
              state_d = S_ISSUE;
              addr_d  = sdram_rdaddr_begin;
              end_d   = sdram_rdaddr_end;
              write_d = 1'b0;
              count_d = '0;
              done_d  = 1'b0;
              valid_d = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          if (pre_e) begin
            pre_clr_d = 1'b1;
            err_d     = 1'b0;
          end
          if (post_e) post_clr_d = 1'b1;
        end
      end

      S_ISSUE: begin
        if (|req_edge) err_d = 1'b1;
        if (valid_q) begin
          if (cmd_ready) begin
            valid_d = 1'b0;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            // Compare before incrementing so an all-ones end never wraps.
            if (addr_q == end_q) state_d = S_FLUSH;
            else                 addr_d  = addr_q + 1'b1;
          end
        end else if (gate_open) begin
          valid_d = 1'b1;
        end
      end

      S_FLUSH: begin
        if (|req_edge) err_d = 1'b1;
        if (ctrl_idle) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) begin
      req_cur_q  <= '0;
      req_prev_q <= '0;
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      end_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pre_clr_q  <= 1'b0;
      post_clr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      req_cur_q  <= {sdram_post_clr, sdram_pre_clr, sdram_rd, sdram_wr};
      req_prev_q <= req_cur_q;
      state_q    <= state_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pre_clr_q  <= pre_clr_d;
      post_clr_q <= post_clr_d;
    end
  end

  assign cmd_valid     = valid_q;
  assign cmd_write     = write_q;
  assign cmd_addr      = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign xfer_done     = done_q;
  assign xfer_count    = count_q;
  assign seq_error     = err_q;
  assign pre_fifo_clr  = pre_clr_q;
  assign post_fifo_clr = post_clr_q;

endmodule

// File: tb/tb_sdram_xfer_seq.sv
// Scoreboard bench for sdram_xfer_seq: expected commands are queued by the stimulus
// and popped by an independent monitor on every accepted command.
module tb_sdram_xfer_seq;

  logic        clk = 1'b0;
  logic        pRST;
  logic        sdram_wr, sdram_rd, sdram_pre_clr, sdram_post_clr;
  logic [15:0] sdram_wraddr_begin, sdram_wraddr_end, sdram_rdaddr_begin, sdram_rdaddr_end;
  logic [9:0]  wfifo_used, rfifo_free;
  logic        cmd_valid, cmd_ready, cmd_write, ctrl_idle;
  logic [15:0] cmd_addr;
  logic        pre_fifo_clr, post_fifo_clr, busy, xfer_done, seq_error;
  logic [15:0] xfer_count;

  typedef struct {
    logic        w;
    logic [15:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sdram_xfer_seq dut (
    .clk               (clk),
    .pRST              (pRST),
    .sdram_wr          (sdram_wr),
    .sdram_rd          (sdram_rd),
    .sdram_wraddr_begin(sdram_wraddr_begin),
    .sdram_wraddr_end  (sdram_wraddr_end),
    .sdram_rdaddr_begin(sdram_rdaddr_begin),
    .sdram_rdaddr_end  (sdram_rdaddr_end),
    .sdram_pre_clr     (sdram_pre_clr),
    .sdram_post_clr    (sdram_post_clr),
    .wfifo_used        (wfifo_used),
    .rfifo_free        (rfifo_free),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .ctrl_idle         (ctrl_idle),
    .pre_fifo_clr      (pre_fifo_clr),
    .post_fifo_clr     (post_fifo_clr),
    .busy              (busy),
    .xfer_done         (xfer_done),
    .xfer_count        (xfer_count),
    .seq_error         (seq_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an accept is valid&ready seen on the falling edge, taken at the next rising edge.
  always @(negedge clk) begin
    if (!pRST && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {cmd_write, cmd_addr}, 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cmd_addr", cmd_addr, e.a);
        check("cmd_write", cmd_write, e.w);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [15:0] a);
    exp_t e;
    e.w = w;
    e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_qempty(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!xfer_done && n < max) begin
      tick(1);
      n++;
    end
    check({name, "_done"}, xfer_done, 1);
  endtask

  initial begin
    pRST = 1'b1;
    {sdram_wr, sdram_rd, sdram_pre_clr, sdram_post_clr} = '0;
    sdram_wraddr_begin = '0; sdram_wraddr_end = '0;
    sdram_rdaddr_begin = '0; sdram_rdaddr_end = '0;
    wfifo_used = '0; rfifo_free = '0;
    cmd_ready = 1'b0; ctrl_idle = 1'b0;
    tick(3);
    pRST = 1'b0;
    tick(2);

    // Reset state
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", xfer_done, 0);
    check("rst_count", xfer_count, 0);
    check("rst_err", seq_error, 0);
    check("rst_clr", {pre_fifo_clr, post_fifo_clr, cmd_write}, 0);

    // 1. Write run 0x10..0x13
    sdram_wraddr_begin = 16'h0010; sdram_wraddr_end = 16'h0013;
    wfifo_used = 10'd8; cmd_ready = 1'b1; ctrl_idle = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 16'h0010 + 16'(i));
    sdram_wr = 1'b1;
    wait_qempty("wr_run", 60);
    tick(3);
    check("wr_flush_busy", busy, 1);
    check("wr_flush_nodone", xfer_done, 0);
    check("wr_count", xfer_count, 4);
    ctrl_idle = 1'b1;
    wait_done("wr_run", 10);
    check("wr_idle", busy, 0);
    sdram_wr = 1'b0;
    tick(2);

    // 2/3. Read gating then backpressure, single burst at 0x00
    sdram_rdaddr_begin = 16'h0000; sdram_rdaddr_end = 16'h0000;
    rfifo_free = 10'd4; cmd_ready = 1'b0;
    push(1'b0, 16'h0000);
    sdram_rd = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (cmd_valid) seen++;
      end
      check("rd_gated", seen, 0);
    end
    check("rd_busy", busy, 1);
    rfifo_free = 10'd8;
    tick(2);
    check("rd_valid", cmd_valid, 1);
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        if (!cmd_valid || cmd_addr != 16'h0000 || cmd_write || xfer_count != 0) bad++;
      end
      check("bp_stable", bad, 0);
    end
    cmd_ready = 1'b1;
    wait_done("rd_run", 20);
    check("rd_count", xfer_count, 1);
    check("rd_err", seq_error, 0);
    sdram_rd = 1'b0;
    tick(2);

    // 4a. end < begin on write
    sdram_wraddr_begin = 16'h0005; sdram_wraddr_end = 16'h0004;
    sdram_wr = 1'b1;
    tick(3);
    check("bad_range_err", seq_error, 1);
    check("bad_range_busy", busy, 0);
    sdram_wr = 1'b0;
    tick(2);

    // 4b. pre_clr edge in idle clears error and pulses once
    sdram_pre_clr = 1'b1;
    tick(2);
    check("pre_pulse", pre_fifo_clr, 1);
    check("pre_err_clr", seq_error, 0);
    tick(1);
    check("pre_pulse_end", pre_fifo_clr, 0);
    sdram_pre_clr = 1'b0;
    tick(2);

    // 4c. wr and rd in the same cycle
    sdram_wraddr_begin = 16'h0001; sdram_wraddr_end = 16'h0002;
    sdram_wr = 1'b1; sdram_rd = 1'b1;
    tick(3);
    check("both_err", seq_error, 1);
    check("both_busy", busy, 0);
    sdram_wr = 1'b0; sdram_rd = 1'b0;
    tick(2);

    // Both clears together fire both pulses
    sdram_pre_clr = 1'b1; sdram_post_clr = 1'b1;
    tick(2);
    check("dual_pulse", {pre_fifo_clr, post_fifo_clr}, 2'b11);
    check("dual_err_clr", seq_error, 0);
    sdram_pre_clr = 1'b0; sdram_post_clr = 1'b0;
    tick(2);

    // 4d. rd edge mid-run flags error, run still completes
    sdram_wraddr_begin = 16'h0020; sdram_wraddr_end = 16'h0021;
    ctrl_idle = 1'b0;
    push(1'b1, 16'h0020); push(1'b1, 16'h0021);
    sdram_wr = 1'b1;
    tick(3);
    check("mid_busy", busy, 1);
    sdram_rd = 1'b1;
    tick(3);
    check("mid_err", seq_error, 1);
    wait_qempty("mid_run", 40);
    tick(2);
    check("mid_still_busy", busy, 1);
    ctrl_idle = 1'b1;
    wait_done("mid_run", 10);
    check("mid_count", xfer_count, 2);
    sdram_wr = 1'b0; sdram_rd = 1'b0;
    tick(2);

    // 5a. begin=end=0xFFFF: exactly one command, no wrap
    sdram_wraddr_begin = 16'hFFFF; sdram_wraddr_end = 16'hFFFF;
    push(1'b1, 16'hFFFF);
    sdram_wr = 1'b1;
    wait_done("top_run", 40);
    tick(10);
    check("top_count", xfer_count, 1);
    check("top_idle", busy, 0);
    sdram_wr = 1'b0;
    tick(2);

    // 5b. Reset during ISSUE with a command held
    sdram_wraddr_begin = 16'h0030; sdram_wraddr_end = 16'h0035;
    cmd_ready = 1'b0;
    sdram_wr = 1'b1;
    begin
      int n = 0;
      while (!cmd_valid && n < 20) begin
        tick(1);
        n++;
      end
      check("pre_rst_valid", cmd_valid, 1);
    end
    #2 pRST = 1'b1;
    #1;
    check("rst_mid_valid", cmd_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", xfer_done, 0);
    sdram_wr = 1'b0;
    tick(2);
    pRST = 1'b0;
    tick(4);
    check("post_rst_busy", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
